// File: rtl/xorframe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xorframe_pkg                                                         |
// | Shared types, constants and the Galois LFSR step for xorframe_gen.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package xorframe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    EXP  = 2'd3
  } state_e;

  localparam logic [7:0] LFSR_TAPS_DEFAULT = 8'hB8;
  localparam int         LFSR_MAXW         = 64;

  // Callers zero-extend into the wide form and truncate the result back to
  // their own width, which keeps the step modulo the caller's data width.
  function automatic logic [LFSR_MAXW-1:0] lfsr_step(
    input logic [LFSR_MAXW-1:0] x,
    input logic [LFSR_MAXW-1:0] taps
  );
    return (x >> 1) ^ (x[0] ? taps : '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/xorframe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xorframe_if                                                          |
// | Command, FIFO-push and expected-result ports of xorframe_gen. The     |
// | exp signals are only active when XORFRAME_EXP_EN is defined.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface xorframe_if #(
  parameter int DWIDTH = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_len;
  logic [DWIDTH-1:0] cmd_seed;
  logic              ofifo_not_full;
  logic              ofifo_push;
  logic [DWIDTH-1:0] odata;
  logic              exp_valid;
  logic              exp_ready;
  logic [DWIDTH-1:0] exp_data;
  logic [15:0]       frame_cnt;
  logic              gen_idle;

  modport master (
    input  cmd_valid, cmd_len, cmd_seed, ofifo_not_full, exp_ready,
    output cmd_ready, ofifo_push, odata, exp_valid, exp_data, frame_cnt, gen_idle
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_seed, ofifo_not_full, exp_ready,
    input  cmd_ready, ofifo_push, odata, exp_valid, exp_data, frame_cnt, gen_idle
  );
endinterface
`default_nettype wire

// File: rtl/xorframe_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xorframe_lfsr                                                        |
// | Loadable / advanceable Galois LFSR register; q_next is step(q).       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module xorframe_lfsr
  import xorframe_pkg::*;
#(
  parameter int              DWIDTH = 8,
  parameter logic [DWIDTH-1:0] TAPS = DWIDTH'(LFSR_TAPS_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DWIDTH-1:0] seed,
  input  logic              adv,
  output logic [DWIDTH-1:0] q,
  output logic [DWIDTH-1:0] q_next
);

  logic [DWIDTH-1:0] lfsr_q;
  logic [DWIDTH-1:0] lfsr_d;

  assign q_next = DWIDTH'(lfsr_step(LFSR_MAXW'(lfsr_q), LFSR_MAXW'(TAPS)));
  assign q      = lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (adv) begin
      lfsr_d = q_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= DWIDTH'(1);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/xorframe_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xorframe_gen                                                         |
// | Emits count-prefixed LFSR frames into the xorexec input FIFO and,     |
// | with XORFRAME_EXP_EN defined, offers each frame's payload XOR.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module xorframe_gen
  import xorframe_pkg::*;
#(
  parameter int                DWIDTH    = 8,   // 8..64
  parameter logic [DWIDTH-1:0] LFSR_TAPS = DWIDTH'(LFSR_TAPS_DEFAULT)
) (
  input  logic      clk,
  input  logic      rst,
  xorframe_if.master bus
);

  state_e            state_q, state_d;
  logic [7:0]        rem_q, rem_d;
  logic [DWIDTH-1:0] odata_q, odata_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              have_byte;
  logic              push;
  logic              accept;
  logic              lfsr_adv;
  logic [DWIDTH-1:0] lfsr_seed;
  logic [DWIDTH-1:0] lfsr_q;
  logic [DWIDTH-1:0] lfsr_next;

  assign have_byte = (state_q == HDR) || (state_q == PAY);
  // Combinational so a full FIFO is never pushed and reset kills it at once.
  assign push      = have_byte && bus.ofifo_not_full && !rst;
  assign accept    = (state_q == IDLE) && bus.cmd_valid && (bus.cmd_len != 8'd0);
  assign lfsr_adv  = (state_q == PAY) && push;
  assign lfsr_seed = (bus.cmd_seed == '0) ? DWIDTH'(1) : bus.cmd_seed;

  xorframe_lfsr #(
    .DWIDTH (DWIDTH),
    .TAPS   (LFSR_TAPS)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .seed   (lfsr_seed),
    .adv    (lfsr_adv),
    .q      (lfsr_q),
    .q_next (lfsr_next)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    odata_d     = odata_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rem_d   = bus.cmd_len;
          odata_d = DWIDTH'(bus.cmd_len);
          state_d = HDR;
        end
      end
      HDR: begin
        if (push) begin
          odata_d = lfsr_q;
          state_d = PAY;
        end
      end
      PAY: begin
        if (push) begin
          odata_d = lfsr_next;
          rem_d   = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef XORFRAME_EXP_EN
            state_d = EXP;
`else
            state_d = IDLE;
`endif
          end
        end
      end
      EXP: begin
        if (bus.exp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= 8'd0;
      odata_q     <= '0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      odata_q     <= odata_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef XORFRAME_EXP_EN
  logic [DWIDTH-1:0] acc_q, acc_d;

  // odata_q holds the payload byte being pushed, so it folds in on the push.
  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      acc_d = '0;
    end else if (lfsr_adv) begin
      acc_d = acc_q ^ odata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign bus.exp_valid = (state_q == EXP);
  assign bus.exp_data  = acc_q;
`else
  logic unused_exp_ready;
  assign unused_exp_ready = bus.exp_ready;
  assign bus.exp_valid    = 1'b0;
  assign bus.exp_data     = '0;
`endif

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.gen_idle   = (state_q == IDLE);
  assign bus.ofifo_push = push;
  assign bus.odata      = odata_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_xorframe_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_xorframe_gen                                                      |
// | Directed + randomized bench with a byte-list reference model.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_xorframe_gen;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   model_cnt = 0;
  logic [7:0] got[$];

  xorframe_if #(.DWIDTH(8)) bus ();

  xorframe_gen #(.DWIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_step(input logic [7:0] x);
    return x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
  endfunction

  // Pushes are recorded on the falling edge; a push is illegal while the FIFO is full or in reset.
  always @(negedge clk) begin
    if (rst) begin
      chk("push_in_reset", 32'(bus.ofifo_push), 32'd0);
    end else begin
      if (!bus.ofifo_not_full) chk("push_while_full", 32'(bus.ofifo_push), 32'd0);
      if (bus.ofifo_push === 1'b1) got.push_back(bus.odata);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input int len, input logic [7:0] seed);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = len[7:0];
    bus.cmd_seed  = seed;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    chk("gen_idle_idle", 32'(bus.gen_idle), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = 8'($urandom);
    bus.cmd_seed  = 8'($urandom);
  endtask

  // bp: 0 none, 1 random, 2 five-cycle stalls after header and before last byte
  task automatic run_frame(input int len, input logic [7:0] seed, input int bp, input int stall);
    logic [7:0] expb[$];
    logic [7:0] x;
    logic [7:0] xr;
    int cyc, s1, s2;
    expb = {};
    expb.push_back(len[7:0]);
    x  = (seed == 8'd0) ? 8'd1 : seed;
    xr = 8'd0;
    for (int i = 0; i < len; i++) begin
      expb.push_back(x);
      xr = xr ^ x;
      x  = ref_step(x);
    end
    got = {};
    issue_cmd(len, seed);
    cyc = 0; s1 = 0; s2 = 0;
    while (got.size() < len + 1 && cyc < 3000) begin
      case (bp)
        0: bus.ofifo_not_full = 1'b1;
        1: bus.ofifo_not_full = ($urandom_range(0, 2) != 0);
        default: begin
          if (got.size() == 1 && s1 < 5) begin
            bus.ofifo_not_full = 1'b0; s1++;
          end else if (got.size() == len && s2 < 5) begin
            bus.ofifo_not_full = 1'b0; s2++;
          end else begin
            bus.ofifo_not_full = 1'b1;
          end
        end
      endcase
      @(negedge clk);
      tick();
      cyc++;
    end
    bus.ofifo_not_full = 1'b1;
    chk("frame_timeout", 32'(cyc < 3000), 32'd1);
    if (bp == 0) chk("push_cycles", 32'(cyc), 32'(len + 1));
    chk("byte_count", 32'(got.size()), 32'(len + 1));
    for (int i = 0; i < expb.size() && i < got.size(); i++)
      chk($sformatf("byte[%0d]", i), 32'(got[i]), 32'(expb[i]));
    model_cnt = (model_cnt + 1) % 65536;
`ifdef XORFRAME_EXP_EN
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("exp_valid_stall", 32'(bus.exp_valid), 32'd1);
      chk("exp_data_stall", 32'(bus.exp_data), 32'(xr));
      chk("cmd_ready_stall", 32'(bus.cmd_ready), 32'd0);
      tick();
    end
    bus.exp_ready = 1'b1;
    @(negedge clk);
    chk("exp_valid", 32'(bus.exp_valid), 32'd1);
    chk("exp_data", 32'(bus.exp_data), 32'(xr));
    chk("cmd_ready_exp", 32'(bus.cmd_ready), 32'd0);
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(model_cnt));
    tick();
    bus.exp_ready = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_exp", 32'(bus.cmd_ready), 32'd1);
    chk("no_extra_push", 32'(bus.ofifo_push), 32'd0);
    tick();
`else
    @(negedge clk);
    chk("cmd_ready_after_last", 32'(bus.cmd_ready), 32'd1);
    chk("exp_valid_off", 32'(bus.exp_valid), 32'd0);
    chk("exp_data_off", 32'(bus.exp_data), 32'd0);
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(model_cnt));
    chk("no_extra_push", 32'(bus.ofifo_push), 32'd0);
    tick();
    if (stall < 0) chk("unreachable", 32'd0, 32'd0);
`endif
    chk("byte_count_final", 32'(got.size()), 32'(len + 1));
  endtask

  initial begin
    rst                = 1'b1;
    bus.cmd_valid      = 1'b0;
    bus.cmd_len        = 8'd0;
    bus.cmd_seed       = 8'd0;
    bus.ofifo_not_full = 1'b1;
    bus.exp_ready      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_gen_idle", 32'(bus.gen_idle), 32'd1);
    chk("rst_push", 32'(bus.ofifo_push), 32'd0);
    chk("rst_exp_valid", 32'(bus.exp_valid), 32'd0);
    chk("rst_odata", 32'(bus.odata), 32'd0);
    chk("rst_exp_data", 32'(bus.exp_data), 32'd0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    tick();

    run_frame(3, 8'h01, 0, 0);
    run_frame(1, 8'h00, 0, 0);
    run_frame(3, 8'h01, 2, 0);

    got = {};
    issue_cmd(0, 8'h77);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("zero_len_idle", 32'(bus.gen_idle), 32'd1);
      chk("zero_len_exp", 32'(bus.exp_valid), 32'd0);
      tick();
    end
    chk("zero_len_pushes", 32'(got.size()), 32'd0);
    chk("zero_len_cnt", 32'(bus.frame_cnt), 32'(model_cnt));
    run_frame(2, 8'h5C, 0, 0);

    run_frame(int'($urandom_range(1, 20)), 8'($urandom), 0, 4);

    // Reset after the header and two of four payload bytes.
    got = {};
    issue_cmd(4, 8'($urandom));
    for (int k = 0; k < 20 && got.size() < 3; k++) begin
      @(negedge clk);
      tick();
    end
    chk("pre_reset_pushes", 32'(got.size()), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_push_drop", 32'(bus.ofifo_push), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 32'(bus.gen_idle), 32'd1);
    chk("post_reset_cnt", 32'(bus.frame_cnt), 32'd0);
    model_cnt = 0;
    tick();
    run_frame(4, 8'($urandom), 0, 0);

    run_frame(255, 8'($urandom), 1, 1);
    for (int f = 0; f < 10; f++)
      run_frame(int'($urandom_range(1, 40)), 8'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
